// File: rtl/wb_pipe_ram_pkg.sv
// Shared types and constants for the pipelined Wishbone RAM model.
// The LFSR helper is only used when WB_PIPE_RAM_STALL_INJECT_EN is defined.
package wb_pipe_ram_pkg;

    localparam int          MAX_LATENCY   = 7;
    localparam int          MAX_STALL_RUN = 8;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/wb_pipe_ram_resp.sv
// LATENCY-deep delay line of responses; flush empties every stage on the next edge.
module wb_resp_pipe
    import wb_pipe_ram_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  resp_t din,
    output resp_t dout
);

    resp_t [LATENCY-1:0] stage;

    generate
        if (LATENCY == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage <= '0;
                else        stage <= flush ? '0 : din;
            end
        end else begin : g_many
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage <= '0;
                else        stage <= flush ? '0 : {stage[LATENCY-2:0], din};
            end
        end
    endgenerate

    assign dout = stage[LATENCY-1];

endmodule

// File: rtl/wb_pipe_ram.sv
// Pipelined Wishbone B4 slave RAM with fixed response latency and bounded outstanding count.
// Optional random stall injection: define WB_PIPE_RAM_STALL_INJECT_EN.
module wb_pipe_ram
    import wb_pipe_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    MEM_WORDS       = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    LATENCY         = 1,
    parameter int                    MAX_OUTSTANDING = 2
`ifdef WB_PIPE_RAM_STALL_INJECT_EN
    ,
    parameter int                    STALL_RATE      = 4,
    parameter logic [15:0]           LFSR_SEED       = 16'hACE1
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic                    stall_o,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);

    localparam int MAX_INDEX = MEM_WORDS;
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [ADDR_WIDTH-1:0] off, idx;
    logic [IDX_W-1:0]      widx;
    logic                  bad, accept, resp_fire, cnt_stall;
    logic [CNT_W-1:0]      cnt;
    resp_t                 din, dout;

    assign off    = adr_i - BASE_ADDR;
    assign idx    = off >> 2;
    assign widx   = idx[IDX_W-1:0];
    assign bad    = (adr_i[1:0] != 2'b00) || (adr_i < BASE_ADDR) ||
                    (idx >= ADDR_WIDTH'(MAX_INDEX));
    assign accept = cyc_i & stb_i & ~stall_o;

    // Read data is captured at accept so later writes cannot alter it in flight
    always_comb begin
        din       = '0;
        din.valid = accept;
        din.err   = accept & bad;
        if (accept && !bad && !we_i) din.data = mem[widx];
    end

    // RAM has no reset: contents survive rst_n and dropped cycles
    always_ff @(posedge clk) begin
        if (accept && we_i && !bad) begin
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (sel_i[b]) mem[widx][8*b +: 8] <= dat_i[8*b +: 8];
        end
    end

    wb_resp_pipe #(.LATENCY(LATENCY)) u_resp (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (~cyc_i),
        .din   (din),
        .dout  (dout)
    );

    assign resp_fire = dout.valid & cyc_i;
    assign ack_o     = resp_fire & ~dout.err;
    assign err_o     = resp_fire & dout.err;
    assign dat_o     = ack_o ? dout.data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt <= '0;
        else if (!cyc_i)               cnt <= '0;
        else if (accept && !resp_fire) cnt <= cnt + 1'b1;
        else if (!accept && resp_fire) cnt <= cnt - 1'b1;
    end

    assign cnt_stall = (cnt == CNT_W'(MAX_OUTSTANDING));

`ifdef WB_PIPE_RAM_STALL_INJECT_EN
    logic [15:0] lfsr;
    logic [3:0]  run;
    logic        inj;

    // Capping the run bounds how long a strobe can wait for acceptance
    assign inj = (lfsr[3:0] < 4'(STALL_RATE)) && (run < 4'(MAX_STALL_RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
            run  <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            run  <= inj ? run + 1'b1 : 4'd0;
        end
    end

    assign stall_o = cnt_stall | inj;
`else
    assign stall_o = cnt_stall;
`endif

endmodule

// File: tb/tb_wb_pipe_ram.sv
// Directed bench: LATENCY=1 and LATENCY=3 instances share data/address inputs,
// single transactions come from a vector table, multi-cycle corners are hand sequences.
module tb_wb_pipe_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc1, stb1, cyc3, stb3, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        stall1, ack1, err1, stall3, ack3, err3;
    logic [31:0] dat1, dat3;

    always #5 clk = ~clk;

    wb_pipe_ram #(.LATENCY(1), .MAX_OUTSTANDING(2)) u_l1 (
        .clk(clk), .rst_n(rst_n), .cyc_i(cyc1), .stb_i(stb1), .we_i(we),
        .adr_i(adr), .sel_i(sel), .dat_i(dat),
        .stall_o(stall1), .ack_o(ack1), .err_o(err1), .dat_o(dat1));

    wb_pipe_ram #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_l3 (
        .clk(clk), .rst_n(rst_n), .cyc_i(cyc3), .stb_i(stb3), .we_i(we),
        .adr_i(adr), .sel_i(sel), .dat_i(dat),
        .stall_o(stall3), .ack_o(ack3), .err_o(err3), .dat_o(dat3));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[17];

    // One request to both instances; L1 answers 1 cycle later, L3 three cycles later
    task automatic txn(input vec_t v, input string nm);
        logic [33:0] exp;
        exp = {~v.err, v.err, (v.we || v.err) ? 32'h0 : v.rd};
        @(posedge clk); #1;
        cyc1 = 1; cyc3 = 1; stb1 = 1; stb3 = 1;
        we = v.we; adr = v.adr; sel = v.sel; dat = v.dat;
        @(negedge clk);
        chk({nm, " stall"}, {stall1, stall3}, 2'b00);
        @(posedge clk); #1;
        stb1 = 0; stb3 = 0; we = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("%s L1 c%0d", nm, k), {ack1, err1, dat1}, (k == 1) ? exp : 34'h0);
            chk($sformatf("%s L3 c%0d", nm, k), {ack3, err3, dat3}, (k == 3) ? exp : 34'h0);
        end
    endtask

`ifdef WB_PIPE_RAM_STALL_INJECT_EN
    logic        ci, si, wei, stalli, acki, erri;
    logic [31:0] adri, dati, dato_i;
    int          cyc_cnt = 0, run_cur = 0, run_max = 0, late = 0, bad_dat = 0, n_resp = 0, hang = 0;
    bit          inj_on = 0;
    logic [31:0] qdat[$];
    int          qt[$];
    logic [31:0] model[64];
    bit          written[64];

    wb_pipe_ram #(.LATENCY(7), .MAX_OUTSTANDING(8), .STALL_RATE(15)) u_inj (
        .clk(clk), .rst_n(rst_n), .cyc_i(ci), .stb_i(si), .we_i(wei),
        .adr_i(adri), .sel_i(4'hF), .dat_i(dati),
        .stall_o(stalli), .ack_o(acki), .err_o(erri), .dat_o(dato_i));

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (inj_on) begin
            if (stalli) run_cur++; else run_cur = 0;
            if (run_cur > run_max) run_max = run_cur;
            if (acki || erri) begin
                if (erri || qdat.size() == 0) bad_dat++;
                else begin
                    if (dato_i !== qdat[0]) bad_dat++;
                    if (cyc_cnt - qt[0] > 16) late++;
                    void'(qdat.pop_front());
                    void'(qt.pop_front());
                    n_resp++;
                end
            end
        end
    end
`endif

    int          sched[6];
    int          ex_ack[10];
    logic [31:0] ra[4], rdv[4];
    logic [9:0]  es;

    initial begin
        vt[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h10,   4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 32'h20,   4'hF, 32'h11223344, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h20,   4'h2, 32'h0000AB00, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h20,   4'hF, 32'h0,        1'b0, 32'h1122AB44};
        vt[5]  = '{1'b1, 32'h30,   4'hF, 32'hAABBCCDD, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 32'h30,   4'h9, 32'h11223344, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 32'h30,   4'hF, 32'h0,        1'b0, 32'h11BBCC44};
        vt[8]  = '{1'b1, 32'h0,    4'hF, 32'h0BADF00D, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 32'h4002, 4'hF, 32'h0,        1'b1, 32'h0};
        vt[10] = '{1'b0, 32'h4000, 4'hF, 32'h0,        1'b1, 32'h0};
        vt[11] = '{1'b1, 32'h4000, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
        vt[12] = '{1'b1, 32'h11,   4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
        vt[13] = '{1'b0, 32'h0,    4'hF, 32'h0,        1'b0, 32'h0BADF00D};
        vt[14] = '{1'b0, 32'h10,   4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[15] = '{1'b1, 32'h3FFC, 4'hF, 32'h12345678, 1'b0, 32'h0};
        vt[16] = '{1'b0, 32'h3FFC, 4'hF, 32'h0,        1'b0, 32'h12345678};

        rst_n = 0; cyc1 = 0; stb1 = 0; cyc3 = 0; stb3 = 0; we = 0;
        adr = 0; dat = 0; sel = 4'hF;
`ifdef WB_PIPE_RAM_STALL_INJECT_EN
        ci = 0; si = 0; wei = 0; adri = 0; dati = 0;
`endif
        repeat (3) @(negedge clk);
        chk("reset L1", {stall1, ack1, err1, dat1}, 35'h0);
        chk("reset L3", {stall3, ack3, err3, dat3}, 35'h0);
        @(posedge clk); #1 rst_n = 1;

        for (int i = 0; i < 17; i++) txn(vt[i], $sformatf("v%0d", i));

        // Read then overwrite the same word: the read returns the old value
        cyc1 = 0; stb1 = 0;
        @(posedge clk); #1; cyc3 = 1; stb3 = 1; we = 0; adr = 32'h10; sel = 4'hF;
        @(posedge clk); #1; we = 1; dat = 32'hCAFEF00D;
        @(posedge clk); #1; stb3 = 0; we = 0;
        @(negedge clk);
        @(negedge clk); chk("rd before wr", {ack3, err3, dat3}, {2'b10, 32'hDEADBEEF});
        @(negedge clk); chk("wr after rd", {ack3, err3, dat3}, {2'b10, 32'h0});

        // Four back-to-back reads, LATENCY=3 MAX_OUTSTANDING=2
        sched  = '{0, 1, 2, 2, 2, 3};
        ex_ack = '{-1, -1, -1, 0, 1, -1, -1, 2, 3, -1};
        ra     = '{32'h10, 32'h20, 32'h30, 32'h0};
        rdv    = '{32'hCAFEF00D, 32'h1122AB44, 32'h11BBCC44, 32'h0BADF00D};
        es     = 10'b0011001100;
        for (int c = 0; c < 10; c++) begin
            logic [33:0] ev;
            int ix;
            @(posedge clk); #1;
            we = 0;
            if (c < 6) begin stb3 = 1; adr = ra[sched[c]]; end
            else stb3 = 0;
            @(negedge clk);
            ix = ex_ack[c];
            ev = '0;
            if (ix >= 0) ev = {2'b10, rdv[ix]};
            chk($sformatf("b2b stall c%0d", c), stall3, es[c]);
            chk($sformatf("b2b resp c%0d", c), {ack3, err3, dat3}, ev);
        end

        // Drop cyc_i with two reads in flight; strobe while cyc_i low is ignored
        @(posedge clk); #1; cyc3 = 1; stb3 = 1; we = 0; adr = 32'h20;
        @(posedge clk); #1; adr = 32'h30;
        @(posedge clk); #1; cyc3 = 0; we = 1; adr = 32'h10; dat = 32'h0;
        @(negedge clk); chk("drop c2", {ack3, err3}, 2'b00);
        @(posedge clk); #1; cyc3 = 1; we = 0; adr = 32'h10;
        @(negedge clk); chk("drop c3 stall", stall3, 1'b0);
        chk("drop c3", {ack3, err3, dat3}, 34'h0);
        @(posedge clk); #1; stb3 = 0;
        @(negedge clk); chk("drop c4", {ack3, err3, dat3}, 34'h0);
        @(negedge clk); chk("drop c5", {ack3, err3, dat3}, 34'h0);
        @(negedge clk); chk("drop fresh rd", {ack3, err3, dat3}, {2'b10, 32'hCAFEF00D});

        // Asynchronous reset mid-transaction
        @(posedge clk); #1; cyc1 = 1; stb1 = 1; cyc3 = 1; stb3 = 1; we = 0; adr = 32'h20;
        @(posedge clk); #1; stb1 = 0; stb3 = 0;
        #2 rst_n = 0;
        @(negedge clk);
        chk("rst mid L1", {stall1, ack1, err1, dat1}, 35'h0);
        chk("rst mid L3", {stall3, ack3, err3, dat3}, 35'h0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        @(negedge clk); chk("rst mid L3 no ack", {ack3, err3, dat3}, 34'h0);
        txn('{1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'h1122AB44}, "post rst");

`ifdef WB_PIPE_RAM_STALL_INJECT_EN
        inj_on = 1;
        @(posedge clk); #1 ci = 1;
        for (int i = 0; i < 200; i++) begin
            int   a, waited;
            logic w;
            a = $urandom_range(0, 63);
            w = ($urandom_range(0, 1) == 1) || !written[a];
            @(posedge clk); #1;
            si = 1; wei = w; adri = a * 4; dati = $urandom;
            qt.push_back(cyc_cnt);
            waited = 0;
            @(negedge clk);
            while (stalli && waited < 32) begin @(negedge clk); waited++; end
            if (waited >= 32) begin hang++; void'(qt.pop_back()); end
            else if (w) begin
                qdat.push_back(32'h0); model[a] = dati; written[a] = 1;
            end else qdat.push_back(model[a]);
        end
        @(posedge clk); #1 si = 0;
        repeat (40) @(negedge clk);
        chk("inj stall run", run_max <= 8, 1'b1);
        chk("inj late", late, 0);
        chk("inj data", bad_dat, 0);
        chk("inj hang", hang, 0);
        chk("inj resp count", n_resp, 200);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
